acc_act_unit: RTL and testbench

- Sits directly downstream of the MMU result path. Pops SIZE x SIZE 32-bit partial-sum tiles from the MMU result FIFO interface.
- Accumulates cfg_num_tiles consecutive tiles, which covers inner dimensions larger than SIZE.
- Applies optional ReLU, a rounding arithmetic right shift and int8 saturation, then presents one 8-bit output tile to the unified-buffer writer over a valid/ready handshake.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/acc_act_unit_if.sv | 32 +++
 rtl/acc_act_unit_quant_lane.sv | 31 +++
 rtl/acc_act_unit.sv | 124 ++++++++++++
 tb/tb_acc_act_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared widths and state type for the accumulate/activate unit
package tpu_pkg;

   localparam int ACC_W = 32;
   localparam int OUT_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      POP     = 3'd1,
      CAPTURE = 3'd2,
      ACT     = 3'd3,
      OUT     = 3'd4
   } acc_act_state_t;

endpackage

// File: rtl/acc_act_unit_if.sv
// rtl/acc_act_unit_if.sv - MMU result FIFO side and unified-buffer output side of acc_act_unit
interface acc_act_unit_if #(
   parameter int SIZE = 2
);
   import tpu_pkg::*;

   logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] tile_in;
   logic                                 tile_in_rdy;
   logic                                 tile_in_pop;
   logic [SIZE-1:0][SIZE-1:0][OUT_W-1:0] out_tile;
   logic                                 out_valid;
   logic                                 out_ready;

   modport master (
      input  tile_in,
      input  tile_in_rdy,
      input  out_ready,
      output tile_in_pop,
      output out_tile,
      output out_valid
   );

   modport slave (
      output tile_in,
      output tile_in_rdy,
      output out_ready,
      input  tile_in_pop,
      input  out_tile,
      input  out_valid
   );

endinterface

// File: rtl/acc_act_unit_quant_lane.sv
// rtl/acc_act_unit_quant_lane.sv - one element of ReLU, rounding arithmetic shift and int8 saturation
module quant_lane
   import tpu_pkg::*;
(
   input  logic [ACC_W-1:0] i_x,
   input  logic [4:0]       i_shift,
   input  logic             i_relu,
   output logic [OUT_W-1:0] o_y
);

   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   // One extra bit of headroom so the rounding bias can never overflow.
   logic signed [ACC_W:0] w_ext;
   logic signed [ACC_W:0] w_relu;
   logic signed [ACC_W:0] w_bias;
   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_shr;

   assign w_ext  = $signed({i_x[ACC_W-1], i_x});
   assign w_relu = (i_relu && i_x[ACC_W-1]) ? '0 : w_ext;
   assign w_bias = (i_shift == 5'd0) ? '0 : $signed((ACC_W+1)'(1) << (i_shift - 5'd1));
   assign w_sum  = w_relu + w_bias;
   assign w_shr  = w_sum >>> i_shift;

   assign o_y = (w_shr > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                (w_shr < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                w_shr[OUT_W-1:0];

endmodule

// File: rtl/acc_act_unit.sv
// rtl/acc_act_unit.sv - accumulates MMU partial-sum tiles, then quantizes one row per cycle to int8
module acc_act_unit
   import tpu_pkg::*;
#(
   parameter int SIZE = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [7:0]     cfg_num_tiles,
   input  logic [4:0]     cfg_shift,
   input  logic           cfg_relu,
   output logic           busy,
   output logic           done,
   acc_act_unit_if.master bus
);

   localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   acc_act_state_t                       r_state;
   logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] r_acc;
   logic [SIZE-1:0][SIZE-1:0][OUT_W-1:0] r_out_tile;
   logic                                 r_out_valid;
   logic [7:0]                           r_tile_cnt;
   logic [7:0]                           r_num_tiles;
   logic [4:0]                           r_shift;
   logic                                 r_relu;
   logic [ROW_W-1:0]                     r_row_cnt;

   logic [SIZE-1:0][ACC_W-1:0]           w_acc_row;
   logic [SIZE-1:0][OUT_W-1:0]           w_q;
   logic                                 w_more_tiles;
   logic                                 w_last_row;

   assign w_acc_row    = r_acc[r_row_cnt];
   assign w_more_tiles = ({1'b0, r_tile_cnt} + 9'd1) < {1'b0, r_num_tiles};
   assign w_last_row   = (r_row_cnt == ROW_W'(SIZE - 1));

   genvar c;
   generate
      for (c = 0; c < SIZE; c++) begin : g_lane
         quant_lane u_quant_lane (
            .i_x     (w_acc_row[c]),
            .i_shift (r_shift),
            .i_relu  (r_relu),
            .o_y     (w_q[c])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_out_tile  <= '0;
         r_out_valid <= 1'b0;
         r_tile_cnt  <= '0;
         r_num_tiles <= '0;
         r_shift     <= '0;
         r_relu      <= 1'b0;
         r_row_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_num_tiles <= (cfg_num_tiles == 8'd0) ? 8'd1 : cfg_num_tiles;
                  r_shift     <= cfg_shift;
                  r_relu      <= cfg_relu;
                  r_acc       <= '0;
                  r_tile_cnt  <= '0;
                  r_row_cnt   <= '0;
                  r_state     <= POP;
               end
            end
            POP: begin
               if (bus.tile_in_rdy) begin
                  r_state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // FIFO data is valid the cycle after the pop; adds wrap freely.
               for (int r = 0; r < SIZE; r++) begin
                  for (int k = 0; k < SIZE; k++) begin
                     r_acc[r][k] <= r_acc[r][k] + bus.tile_in[r][k];
                  end
               end
               r_tile_cnt <= r_tile_cnt + 8'd1;
               if (w_more_tiles) begin
                  r_state <= POP;
               end else begin
                  r_row_cnt <= '0;
                  r_state   <= ACT;
               end
            end
            ACT: begin
               for (int k = 0; k < SIZE; k++) begin
                  r_out_tile[r_row_cnt][k] <= w_q[k];
               end
               r_row_cnt <= r_row_cnt + ROW_W'(1);
               if (w_last_row) begin
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy            = (r_state != IDLE);
   assign done            = (r_state == OUT) && bus.out_ready;
   assign bus.tile_in_pop = (r_state == POP) && bus.tile_in_rdy;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_tile    = r_out_tile;

endmodule

// File: tb/tb_acc_act_unit.sv
// tb/tb_acc_act_unit.sv - directed and randomized checks of acc_act_unit against a behavioural model
module tb_acc_act_unit;
   import tpu_pkg::*;

   localparam int SIZE = 2;

   typedef logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] tile_t;
   typedef logic [SIZE-1:0][SIZE-1:0][OUT_W-1:0] otile_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cfg_num_tiles = '0;
   logic [4:0] cfg_shift = '0;
   logic       cfg_relu = 1'b0;
   logic       busy;
   logic       done;

   acc_act_unit_if #(.SIZE(SIZE)) bus ();

   acc_act_unit #(.SIZE(SIZE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_num_tiles (cfg_num_tiles),
      .cfg_shift     (cfg_shift),
      .cfg_relu      (cfg_relu),
      .busy          (busy),
      .done          (done),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail = 0;
   int    pop_cnt = 0;
   int    done_cnt = 0;
   bit    rdy_en = 1'b1;
   bit    p_pop;
   tile_t fifo_q[$];
   tile_t job_tiles[$];

   // FIFO model: data appears the cycle after a pop; rdy mirrors occupancy.
   always @(posedge clk) begin
      p_pop = bus.tile_in_pop;
      #1;
      if (p_pop && fifo_q.size() != 0) begin
         bus.tile_in = fifo_q.pop_front();
         pop_cnt++;
      end
      bus.tile_in_rdy = rdy_en && (fifo_q.size() != 0);
   end

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   function automatic tile_t mk(int a, int b, int c, int d);
      tile_t t;
      t[0][0] = a; t[0][1] = b; t[1][0] = c; t[1][1] = d;
      return t;
   endfunction

   function automatic otile_t mko(int a, int b, int c, int d);
      otile_t t;
      t[0][0] = 8'(a); t[0][1] = 8'(b); t[1][0] = 8'(c); t[1][1] = 8'(d);
      return t;
   endfunction

   function automatic otile_t model(int n, int sh, bit relu);
      tile_t  acc;
      otile_t o;
      int     eff;
      longint x, d, q;
      acc = '0;
      eff = (n == 0) ? 1 : n;
      for (int t = 0; t < eff; t++)
         for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
               acc[r][c] = acc[r][c] + job_tiles[t][r][c];
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            x = longint'($signed(acc[r][c]));
            if (relu && x < 0) x = 0;
            d = longint'(1) << sh;
            if (sh > 0) x = x + d / 2;
            q = x / d;
            if ((x % d) != 0 && x < 0) q = q - 1;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            o[r][c] = 8'(q);
         end
      end
      return o;
   endfunction

   task automatic push(input tile_t t);
      fifo_q.push_back(t);
      job_tiles.push_back(t);
   endtask

   task automatic start_job(input int n, input int sh, input bit relu);
      cfg_num_tiles = 8'(n);
      cfg_shift = 5'(sh);
      cfg_relu = relu;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_out(input string name, output int cyc);
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 200) begin
         tick;
         cyc++;
      end
      n_tests++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: out_valid=%b after %0d cycles, expected 1", name, bus.out_valid, cyc);
      end
   endtask

   task automatic check_lat(input string name, input int cyc, input int exp);
      n_tests++;
      if (cyc != exp) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp);
      end
   endtask

   task automatic finish_out(input string name, input otile_t exp, input int stall, input int done0);
      otile_t held;
      int     pops0;
      n_tests++;
      if (bus.out_tile !== exp) begin
         n_fail++;
         $display("FAIL %s out_tile: got %h expected %h", name, bus.out_tile, exp);
      end
      if (stall > 0) begin
         held = bus.out_tile;
         pops0 = pop_cnt;
         start = 1'b1;
         for (int i = 0; i < stall; i++) begin
            tick;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_tile !== held || busy !== 1'b1 ||
                done !== 1'b0 || pop_cnt != pops0) begin
               n_fail++;
               $display("FAIL %s stall%0d: valid=%b busy=%b done=%b pops=%0d tile=%h, expected 1 1 0 %0d %h",
                        name, i, bus.out_valid, busy, done, pop_cnt, bus.out_tile, pops0, held);
            end
         end
         start = 1'b0;
      end
      bus.out_ready = 1'b1;
      #1;
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done on handshake: got %b expected 1", name, done);
      end
      tick;
      n_tests++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done_cnt != done0 + 1) begin
         n_fail++;
         $display("FAIL %s after handshake: valid=%b busy=%b dones=%0d, expected 0 0 %0d",
                  name, bus.out_valid, busy, done_cnt - done0, 1);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.tile_in_pop !== 1'b0 ||
          bus.out_valid !== 1'b0 || bus.out_tile !== '0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b pop=%b valid=%b tile=%h, expected all 0",
                  busy, done, bus.tile_in_pop, bus.out_valid, bus.out_tile);
      end
   endtask

   task automatic test_single_tile;
      int cyc, done0;
      job_tiles.delete();
      push(mk(1, -2, 3, 300));
      done0 = done_cnt;
      bus.out_ready = 1'b1;
      start_job(1, 0, 0);
      wait_out("single", cyc);
      check_lat("single", cyc, 5);
      finish_out("single", mko(1, -2, 3, 127), 0, done0);
   endtask

   task automatic test_multi_tile;
      int cyc, done0, pops0;
      job_tiles.delete();
      for (int i = 0; i < 3; i++) push(mk(10, 10, 10, 10));
      done0 = done_cnt;
      pops0 = pop_cnt;
      start_job(3, 1, 0);
      wait_out("multi", cyc);
      check_lat("multi", cyc, 2 * 3 + SIZE + 1);
      n_tests++;
      if (pop_cnt - pops0 != 3) begin
         n_fail++;
         $display("FAIL multi pops: got %0d expected 3", pop_cnt - pops0);
      end
      finish_out("multi", mko(15, 15, 15, 15), 0, done0);
   endtask

   task automatic test_relu_round;
      int cyc, done0;
      job_tiles.delete();
      push(mk(-5, 6, 7, -128));
      done0 = done_cnt;
      start_job(1, 2, 1);
      wait_out("relu1", cyc);
      finish_out("relu1", mko(0, 2, 2, 0), 0, done0);
      job_tiles.delete();
      push(mk(-5, 6, 7, -128));
      done0 = done_cnt;
      start_job(1, 2, 0);
      wait_out("relu0", cyc);
      finish_out("relu0", mko(-1, 2, 2, -32), 5, done0);
   endtask

   task automatic test_input_stall;
      int cyc, done0, pops0;
      job_tiles.delete();
      push(mk(100, 100, 100, 100));
      done0 = done_cnt;
      pops0 = pop_cnt;
      start_job(2, 0, 0);
      repeat (6) tick;
      n_tests++;
      if (pop_cnt - pops0 != 1 || busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.tile_in_pop !== 1'b0) begin
         n_fail++;
         $display("FAIL in_stall: pops=%0d busy=%b valid=%b pop=%b, expected 1 1 0 0",
                  pop_cnt - pops0, busy, bus.out_valid, bus.tile_in_pop);
      end
      push(mk(-30, -30, -30, -30));
      wait_out("in_stall", cyc);
      finish_out("in_stall", mko(70, 70, 70, 70), 0, done0);
   endtask

   task automatic test_saturate_wrap;
      int cyc, done0;
      job_tiles.delete();
      push(mk(-200000, 5, 200000, 0));
      done0 = done_cnt;
      start_job(1, 0, 0);
      wait_out("sat", cyc);
      finish_out("sat", mko(-128, 5, 127, 0), 0, done0);
      job_tiles.delete();
      push(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
      push(mk(1, 1, 1, 1));
      done0 = done_cnt;
      start_job(2, 0, 0);
      wait_out("wrap", cyc);
      finish_out("wrap", mko(-128, -128, -128, -128), 0, done0);
   endtask

   task automatic test_reset_mid_act;
      int cyc, done0;
      job_tiles.delete();
      push(mk(50, 50, 50, 50));
      done0 = done_cnt;
      start_job(1, 0, 0);
      repeat (3) tick;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.tile_in_pop !== 1'b0 || bus.out_tile !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b busy=%b pop=%b tile=%h, expected 0 0 0 0",
                  bus.out_valid, busy, bus.tile_in_pop, bus.out_tile);
      end
      repeat (2) tick;
      rst_n = 1'b1;
      repeat (2) tick;
      n_tests++;
      if (done_cnt != done0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset done: dones=%0d busy=%b expected 0 0", done_cnt - done0, busy);
      end
      job_tiles.delete();
      push(mk(4, 4, 4, 4));
      done0 = done_cnt;
      start_job(1, 0, 0);
      wait_out("post_reset", cyc);
      finish_out("post_reset", mko(4, 4, 4, 4), 0, done0);
   endtask

   task automatic test_random;
      int    n, eff, sh, st, cyc, done0;
      bit    rl, pre;
      int    v[4];
      string name;
      for (int j = 0; j < 10; j++) begin
         n = $urandom_range(0, 4);
         eff = (n == 0) ? 1 : n;
         sh = $urandom_range(0, 31);
         rl = 1'($urandom_range(0, 1));
         pre = 1'($urandom_range(0, 1));
         st = $urandom_range(0, 3);
         name = $sformatf("random%0d", j);
         job_tiles.delete();
         for (int t = 0; t < eff; t++) begin
            for (int e = 0; e < 4; e++) begin
               if ($urandom_range(0, 1) == 1) v[e] = int'($urandom);
               else v[e] = int'($urandom_range(0, 2000)) - 1000;
            end
            push(mk(v[0], v[1], v[2], v[3]));
         end
         done0 = done_cnt;
         bus.out_ready = pre;
         start_job(n, sh, rl);
         wait_out(name, cyc);
         check_lat(name, cyc, 2 * eff + SIZE + 1);
         finish_out(name, model(n, sh, rl), pre ? 0 : st, done0);
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      tick;
      tick;
      test_reset;
      rst_n = 1'b1;
      tick;
      test_reset;
      test_single_tile;
      test_multi_tile;
      test_relu_round;
      test_input_stall;
      test_saturate_wrap;
      test_reset_mid_act;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
